// File: rtl/data_memory_pkg.sv
// Shared rv32 definitions for the data memory: load/store size codes,
// MMIO console addresses and the load-data formatter.
package data_memory_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] MMIO_TX     = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_STATUS = 32'hFFFF_FFF4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TX,
    SEL_STATUS
  } rd_sel_e;

  function automatic logic [31:0] load_format(
    input logic [31:0] w,
    input logic [1:0]  a,
    input logic [2:0]  f3
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    unique case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'b0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Core load/store bus plus console transmit handshake.
// master = core side, slave = data memory side.
interface data_memory_if;

  logic [31:0] dmAddress;
  logic [2:0]  dmFunc3;
  logic        dmWrite;
  logic [31:0] dmDataOut;
  logic [31:0] dmDataIn;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output dmAddress, dmFunc3, dmWrite, dmDataOut, tx_ready,
    input  dmDataIn, tx_data, tx_valid
  );

  modport slave (
    input  dmAddress, dmFunc3, dmWrite, dmDataOut, tx_ready,
    output dmDataIn, tx_data, tx_valid
  );

endinterface

// File: rtl/data_memory_tx_fifo.sv
// Console transmit FIFO with explicit occupancy count.
// A push while full is accepted only when a pop frees a slot that cycle.
module tx_fifo #(
  parameter int TX_DEPTH = 4,
  localparam int AW = $clog2(TX_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(TX_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(TX_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/data_memory.sv
// Byte-lane RAM with registered read, MMIO console TX/STATUS
// and sticky misaligned-store / console-overflow flags.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int TX_DEPTH    = 4
) (
  input  logic         clock,
  input  logic         reset,
  data_memory_if.slave bus,
  output logic         misaligned_fault,
  output logic         tx_overflow
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rdata;
  logic [IW-1:0] widx;
  logic [1:0]    a;
  logic [2:0]    f3;
  logic          is_tx, is_status, is_mmio;
  logic          is_sb, is_sh, is_sw;
  logic          mis, st_ok, ram_we;
  logic [3:0]    be;
  logic [31:0]   wd;

  rd_sel_e    sel_d, sel_q;
  logic [1:0] a_q;
  logic [2:0] f3_q;

  logic          tx_push, tx_pop, tx_drop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;

  assign widx      = bus.dmAddress[IW+1:2];
  assign a         = bus.dmAddress[1:0];
  assign f3        = bus.dmFunc3;
  assign is_tx     = (bus.dmAddress == MMIO_TX);
  assign is_status = (bus.dmAddress == MMIO_STATUS);
  assign is_mmio   = is_tx | is_status;

  assign is_sb = (f3 == F3_B);
  assign is_sh = (f3 == F3_H);
  assign is_sw = (f3 == F3_W);

  assign mis = bus.dmWrite &
               ((is_sh & a[0]) | (is_sw & (a != 2'b00)));
  assign st_ok = bus.dmWrite & (is_sb | is_sh | is_sw) & ~mis;

  assign ram_we  = st_ok & ~is_mmio;
  assign tx_push = st_ok & is_tx;
  assign tx_pop  = bus.tx_ready & ~fifo_empty;
  assign tx_drop = tx_push & fifo_full & ~tx_pop;

  always_comb begin
    be = '0;
    wd = bus.dmDataOut;
    unique case (1'b1)
      is_sb: begin
        be = 4'b0001 << a;
        wd = {4{bus.dmDataOut[7:0]}};
      end
      is_sh: begin
        be = a[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.dmDataOut[15:0]}};
      end
      is_sw:   be = 4'b1111;
      default: ;
    endcase
    if (!ram_we) be = '0;
  end

  // Read-first: rdata sees the word as it was before this cycle's store.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
    end
    rdata <= mem[widx];
  end

  always_comb begin
    sel_d = SEL_RAM;
    if (is_tx)     sel_d = SEL_TX;
    if (is_status) sel_d = SEL_STATUS;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q            <= SEL_NONE;
      a_q              <= '0;
      f3_q             <= '0;
      misaligned_fault <= 1'b0;
      tx_overflow      <= 1'b0;
    end else begin
      sel_q <= sel_d;
      a_q   <= a;
      f3_q  <= f3;
      if (mis)     misaligned_fault <= 1'b1;
      if (tx_drop) tx_overflow      <= 1'b1;
    end
  end

  tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus.dmDataOut[7:0]),
    .pop       (tx_pop),
    .head_data (bus.tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.tx_valid = ~fifo_empty;

  assign status = {28'b0, misaligned_fault, tx_overflow,
                   fifo_empty, ~fifo_full};

  always_comb begin
    bus.dmDataIn = '0;
    unique case (sel_q)
      SEL_RAM:    bus.dmDataIn = load_format(rdata, a_q, f3_q);
      SEL_STATUS: bus.dmDataIn = status;
      default:    ;
    endcase
  end

  a_count_bound: assert property (
    @(posedge clock) disable iff (reset)
    fifo_count <= CW'(TX_DEPTH)
  );

endmodule

// File: tb/tb_data_memory.sv
// Randomized + directed bench for data_memory against a queue/array
// reference model of the load/store/console rules.
module tb_data_memory;

  localparam int DW  = 64;
  localparam int TXD = 4;
  localparam logic [31:0] A_TX = 32'hFFFF_FFF0;
  localparam logic [31:0] A_ST = 32'hFFFF_FFF4;

  logic clock;
  logic reset;
  logic misaligned_fault;
  logic tx_overflow;

  data_memory_if bus();

  data_memory #(.DEPTH_WORDS(DW), .TX_DEPTH(TXD)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .misaligned_fault (misaligned_fault),
    .tx_overflow      (tx_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] mref [DW];
  logic [7:0]  q [$];
  logic        m_fault;
  logic        m_ovf;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] w,
                                      input logic [1:0] a,
                                      input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (a[1] ? 16 : 0));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return 32'(b);
      3'd1:    return 32'($signed(h));
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".valid"}, 32'(bus.tx_valid), 32'(q.size() != 0));
    check({tag, ".txd"}, 32'(bus.tx_data),
          (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check({tag, ".fault"}, 32'(misaligned_fault), 32'(m_fault));
    check({tag, ".ovf"}, 32'(tx_overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic [31:0] addr, input logic [2:0] f3,
                      input logic we, input logic [31:0] d,
                      input logic rdy);
    logic [31:0] rd_word;
    logic [31:0] exp;
    logic [5:0]  idx;
    logic        pop, push, mis;
    int          sel;
    bus.dmAddress = addr;
    bus.dmFunc3   = f3;
    bus.dmWrite   = we;
    bus.dmDataOut = d;
    bus.tx_ready  = rdy;
    idx     = addr[7:2];
    sel     = (addr == A_TX) ? 2 : (addr == A_ST) ? 3 : 1;
    rd_word = mref[idx];
    pop     = rdy && (q.size() != 0);
    push    = 1'b0;
    if (we && f3 <= 3'd2) begin
      mis = (f3 == 3'd1 && addr[0]) ||
            (f3 == 3'd2 && addr[1:0] != 2'b00);
      if (mis) m_fault = 1'b1;
      else if (sel == 2) begin
        if (q.size() == TXD && !pop) m_ovf = 1'b1;
        else push = 1'b1;
      end else if (sel == 1) begin
        case (f3)
          3'd0:    mref[idx][8*addr[1:0] +: 8] = d[7:0];
          3'd1:    mref[idx][16*addr[1] +: 16] = d[15:0];
          default: mref[idx] = d;
        endcase
      end
    end
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d[7:0]);
    @(posedge clock);
    #1;
    case (sel)
      1:       exp = fmt(rd_word, addr[1:0], f3);
      3:       exp = {28'b0, m_fault, m_ovf, q.size() == 0,
                      q.size() != TXD};
      default: exp = 32'h0;
    endcase
    check("rdata", bus.dmDataIn, exp);
    check_outs("step");
  endtask

  task automatic do_reset();
    bus.dmWrite  = 1'b0;
    bus.tx_ready = 1'b0;
    reset = 1'b1;
    #1;
    q.delete();
    m_fault = 1'b0;
    m_ovf   = 1'b0;
    check("rst.rdata", bus.dmDataIn, 32'h0);
    check_outs("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ad;
    reset         = 1'b1;
    bus.dmAddress = '0;
    bus.dmFunc3   = '0;
    bus.dmWrite   = 1'b0;
    bus.dmDataOut = '0;
    bus.tx_ready  = 1'b0;
    m_fault       = 1'b0;
    m_ovf         = 1'b0;
    do_reset();

    for (int i = 0; i < DW; i++) step(32'(i * 4), 3'd2, 1, $urandom(), 0);

    // Load formatting
    step(32'h10, 3'd2, 1, 32'h8081_82F3, 0);
    step(32'h13, 3'd0, 0, 0, 0);
    check("lb13", bus.dmDataIn, 32'hFFFF_FF80);
    step(32'h13, 3'd4, 0, 0, 0);
    check("lbu13", bus.dmDataIn, 32'h0000_0080);
    step(32'h12, 3'd1, 0, 0, 0);
    check("lh12", bus.dmDataIn, 32'hFFFF_8081);
    step(32'h10, 3'd5, 0, 0, 0);
    check("lhu10", bus.dmDataIn, 32'h0000_82F3);

    // Byte and halfword stores
    step(32'h20, 3'd2, 1, 32'h1122_3344, 0);
    step(32'h21, 3'd0, 1, 32'h0000_00AA, 0);
    step(32'h20, 3'd2, 0, 0, 0);
    check("sb21", bus.dmDataIn, 32'h1122_AA44);
    step(32'h22, 3'd1, 1, 32'h0000_5566, 0);
    step(32'h20, 3'd2, 0, 0, 0);
    check("sh22", bus.dmDataIn, 32'h5566_AA44);

    // Read-before-write on the same word
    step(32'h40, 3'd2, 1, 32'h1234_5678, 0);
    step(32'h40, 3'd2, 1, 32'hCAFE_F00D, 0);
    check("rbw.old", bus.dmDataIn, 32'h1234_5678);
    step(32'h40, 3'd2, 0, 0, 0);
    check("rbw.new", bus.dmDataIn, 32'hCAFE_F00D);

    // Unsupported store sizes: no write, no flag
    for (int f = 3; f < 8; f++) step(32'h50, 3'(f), 1, $urandom(), 0);
    step(32'h50, 3'd2, 0, 0, 0);
    check("f3x.fault", 32'(misaligned_fault), 32'h0);
    step(A_ST, 3'd2, 1, 32'hFFFF_FFFF, 0);

    // Misaligned word store
    step(32'h31, 3'd2, 1, 32'hDEAD_BEEF, 0);
    check("mis.fault", 32'(misaligned_fault), 32'h1);
    step(32'h30, 3'd2, 0, 0, 0);
    step(32'h23, 3'd1, 1, 32'h0000_7777, 0);
    step(32'h20, 3'd2, 0, 0, 0);
    check("mis.sh", bus.dmDataIn, 32'h5566_AA44);

    // Console overflow and drain
    for (int i = 0; i < 5; i++) step(A_TX, 3'd0, 1, 32'(8'h41 + i), 0);
    check("ovf", 32'(tx_overflow), 32'h1);
    step(A_ST, 3'd2, 0, 0, 0);
    step(A_TX, 3'd2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("drain", 32'(bus.tx_data), 32'(8'h41 + i));
      step(32'h0, 3'd2, 0, 0, 1);
    end
    check("drained", 32'(bus.tx_valid), 32'h0);

    // Push and pop while full
    for (int i = 0; i < 4; i++) step(A_TX, 3'd0, 1, 32'(8'h41 + i), 0);
    step(A_TX, 3'd0, 1, 32'h46, 1);
    for (int i = 0; i < 4; i++) begin
      ad = (i == 3) ? 32'h46 : 32'(8'h42 + i);
      check("fullpp", 32'(bus.tx_data), ad);
      step(32'h4, 3'd2, 0, 0, 1);
    end
    // Push and pop while empty
    step(A_TX, 3'd0, 1, 32'h47, 1);
    check("emptypp", 32'(bus.tx_data), 32'h47);
    step(A_TX, 3'd2, 1, 32'h48, 0);

    // Reset mid-transfer
    do_reset();
    step(32'h20, 3'd2, 0, 0, 0);
    check("ram.keep", bus.dmDataIn, 32'h5566_AA44);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      ad = $urandom();
      case ($urandom_range(0, 15))
        0:       ad = A_TX;
        1:       ad = A_ST;
        2, 3:    ad = ad | 32'hFFFF_FF00;
        default: ;
      endcase
      if (ad[31:8] == 24'hFFFFFF && ad[7:0] >= 8'hF0 && ad != A_TX)
        ad = A_ST;
      step(ad, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom(), 1'($urandom_range(0, 3) == 0));
      if (n == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
